// File: rtl/lane_queue_counter_pkg.sv
// +----------------------------------------------------------------------+
// | lane_queue_counter_pkg : shared traffic constants (lane count, count |
// | width, lane index names).                      rev 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

package lane_queue_counter_pkg;

  localparam int NUM_LANES = 8;
  localparam int CNT_W     = 8;

  localparam int N1 = 0;
  localparam int N2 = 1;
  localparam int E1 = 2;
  localparam int E2 = 3;
  localparam int S1 = 4;
  localparam int S2 = 5;
  localparam int W1 = 6;
  localparam int W2 = 7;

endpackage

`default_nettype wire

// File: rtl/lane_queue_counter_lane.sv
// +----------------------------------------------------------------------+
// | lane_counter : one lane's edge-detected arrival counter with rate-   |
// | limited departures and a sticky saturation flag.   rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module lane_counter
  import lane_queue_counter_pkg::*;
#(
  parameter int CNT_W       = lane_queue_counter_pkg::CNT_W,
  parameter int DEPART_RATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             arrive,
  input  logic             green,
  input  logic             depart_tick,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W:0] C_RATE = (CNT_W+1)'(DEPART_RATE);
  localparam logic [CNT_W:0] C_MAX  = {1'b0, {CNT_W{1'b1}}};

  logic           r_prev;
  logic           w_arr;
  logic           w_dep;
  logic [CNT_W:0] w_sum;
  logic [CNT_W:0] w_dec;
  logic [CNT_W:0] w_res;

  // One extra bit so arrival at max and the departure floor are both visible.
  always_comb begin
    w_arr = arrive & ~r_prev;
    w_dep = green & depart_tick;
    w_sum = {1'b0, count} + {{CNT_W{1'b0}}, w_arr};
    w_dec = '0;
    if (w_dep) begin
      w_dec = (w_sum < C_RATE) ? w_sum : C_RATE;
    end
    w_res = w_sum - w_dec;
  end

  // prev loads ones on reset so a sensor held through reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
      count  <= '0;
      sat    <= 1'b0;
    end else begin
      r_prev <= arrive;
      if (clr) begin
        count <= '0;
        sat   <= 1'b0;
      end else if (w_res > C_MAX) begin
        count <= C_MAX[CNT_W-1:0];
        sat   <= 1'b1;
      end else begin
        count <= w_res[CNT_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lane_queue_counter.sv
// +----------------------------------------------------------------------+
// | lane_queue_counter : per-lane vehicle queue counters fed by loop     |
// | sensors and drained on green departure ticks.      rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module lane_queue_counter
  import lane_queue_counter_pkg::*;
#(
  parameter int NUM_LANES   = lane_queue_counter_pkg::NUM_LANES,
  parameter int CNT_W       = lane_queue_counter_pkg::CNT_W,
  parameter int DEPART_RATE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            arrive,
  input  logic [NUM_LANES-1:0]            green,
  input  logic                            depart_tick,
  input  logic                            clr,
  output logic [NUM_LANES-1:0][CNT_W-1:0] lane,
  output logic [NUM_LANES-1:0]            sat
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lanes
    lane_counter #(
      .CNT_W       (CNT_W),
      .DEPART_RATE (DEPART_RATE)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .arrive      (arrive[i]),
      .green       (green[i]),
      .depart_tick (depart_tick),
      .count       (lane[i]),
      .sat         (sat[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_lane_queue_counter.sv
// +----------------------------------------------------------------------+
// | tb_lane_queue_counter : directed bench for lane_queue_counter with   |
// | DEPART_RATE 1 (dut_a) and 2 (dut_b) sharing stimulus. rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lane_queue_counter;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      arrive;
  logic [7:0]      green;
  logic            depart_tick;
  logic            clr;
  logic [7:0][7:0] lane_a;
  logic [7:0][7:0] lane_b;
  logic [7:0]      sat_a;
  logic [7:0]      sat_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_queue_counter #(.NUM_LANES(8), .CNT_W(8), .DEPART_RATE(1)) dut_a (
    .clk(clk), .rst(rst), .arrive(arrive), .green(green),
    .depart_tick(depart_tick), .clr(clr), .lane(lane_a), .sat(sat_a)
  );

  lane_queue_counter #(.NUM_LANES(8), .CNT_W(8), .DEPART_RATE(2)) dut_b (
    .clk(clk), .rst(rst), .arrive(arrive), .green(green),
    .depart_tick(depart_tick), .clr(clr), .lane(lane_b), .sat(sat_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      arrive[idx] = 1'b1;
      step();
      arrive[idx] = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arrive = '0; green = '0; depart_tick = 1'b0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (lane_a !== 64'd0) begin
      errors++; $display("FAIL reset_lane got %h want %h", lane_a, 64'd0);
    end
    checks++;
    if (sat_a !== 8'd0) begin
      errors++; $display("FAIL reset_sat got %h want %h", sat_a, 8'd0);
    end
  endtask

  task automatic test_hold_high();
    arrive[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (lane_a[2] !== 8'd1) begin
        errors++; $display("FAIL hold_high cyc%0d got %0d want 1", k, lane_a[2]);
      end
    end
    arrive[2] = 1'b0;
    step();
    checks++;
    if (lane_a[2] !== 8'd1) begin
      errors++; $display("FAIL hold_high_fall got %0d want 1", lane_a[2]);
    end
  endtask

  task automatic test_departure();
    logic [7:0] exp_q [6] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    pulse(0, 5);
    checks++;
    if (lane_a[0] !== 8'd5) begin
      errors++; $display("FAIL depart_fill got %0d want 5", lane_a[0]);
    end
    green[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      depart_tick = 1'b1;
      step();
      depart_tick = 1'b0;
      checks++;
      if (lane_a[0] !== exp_q[k]) begin
        errors++; $display("FAIL depart_%0d got %0d want %0d", k, lane_a[0], exp_q[k]);
      end
      step();
    end
    green[0] = 1'b0;
  endtask

  task automatic test_saturation();
    pulse(7, 255);
    checks++;
    if (lane_a[7] !== 8'd255 || sat_a[7] !== 1'b0) begin
      errors++; $display("FAIL sat_pre got %0d/%b want 255/0", lane_a[7], sat_a[7]);
    end
    pulse(7, 1);
    checks++;
    if (lane_a[7] !== 8'd255 || sat_a[7] !== 1'b1) begin
      errors++; $display("FAIL sat_set got %0d/%b want 255/1", lane_a[7], sat_a[7]);
    end
    green[7] = 1'b1;
    depart_tick = 1'b1;
    step();
    depart_tick = 1'b0;
    green[7] = 1'b0;
    checks++;
    if (lane_a[7] !== 8'd254 || sat_a[7] !== 1'b1) begin
      errors++; $display("FAIL sat_depart got %0d/%b want 254/1", lane_a[7], sat_a[7]);
    end
  endtask

  task automatic test_clr();
    pulse(1, 10);
    checks++;
    if (lane_a[1] !== 8'd10) begin
      errors++; $display("FAIL clr_fill got %0d want 10", lane_a[1]);
    end
    arrive[1] = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (lane_a !== 64'd0 || sat_a !== 8'd0) begin
      errors++; $display("FAIL clr_all got %h/%h want 0/0", lane_a, sat_a);
    end
    step();
    checks++;
    if (lane_a[1] !== 8'd0) begin
      errors++; $display("FAIL clr_prev got %0d want 0", lane_a[1]);
    end
    arrive[1] = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(4, 3);
    checks++;
    if (lane_a[4] !== 8'd3 || lane_b[4] !== 8'd3) begin
      errors++; $display("FAIL simul_fill got %0d/%0d want 3/3", lane_a[4], lane_b[4]);
    end
    arrive[4] = 1'b1;
    green[4] = 1'b1;
    depart_tick = 1'b1;
    step();
    arrive[4] = 1'b0; green[4] = 1'b0; depart_tick = 1'b0;
    checks++;
    if (lane_a[4] !== 8'd3) begin
      errors++; $display("FAIL simul_rate1 got %0d want 3", lane_a[4]);
    end
    checks++;
    if (lane_b[4] !== 8'd2) begin
      errors++; $display("FAIL simul_rate2 got %0d want 2", lane_b[4]);
    end
    step();
  endtask

  task automatic test_reset_held();
    pulse(5, 2);
    arrive[5] = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (lane_a[5] !== 8'd0) begin
      errors++; $display("FAIL rst_discard got %0d want 0", lane_a[5]);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (lane_a[5] !== 8'd0) begin
      errors++; $display("FAIL rst_held got %0d want 0", lane_a[5]);
    end
    step();
    checks++;
    if (lane_a[5] !== 8'd0) begin
      errors++; $display("FAIL rst_held2 got %0d want 0", lane_a[5]);
    end
    arrive[5] = 1'b0;
    step();
    arrive[5] = 1'b1;
    step();
    checks++;
    if (lane_a[5] !== 8'd1) begin
      errors++; $display("FAIL rst_rearm got %0d want 1", lane_a[5]);
    end
    arrive[5] = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    arrive = '0; green = '0; depart_tick = 1'b0; clr = 1'b0;
    test_reset();
    test_hold_high();
    test_departure();
    test_saturation();
    test_clr();
    test_simultaneous();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
